rst_req_gen: RTL and testbench



---
 rtl/rst_req_gen.sv | 171 +++++++++++++++++
 tb/tb_rst_req_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_req_gen.sv
// rtl/rst_req_gen.sv - reset-request generator: debounced button, watchdog and software strobe
// Each accepted event gives a fixed pulse on rst_req, then a holdoff window; the cause is latched.
module rst_req_gen #(
   parameter int DEBOUNCE_CYCLES = 16384,
   parameter int WDT_W           = 24,
   parameter int PULSE_LEN       = 16,
   parameter int HOLDOFF         = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_n,
   input  logic       sw_req,
   input  logic       wdt_en,
   input  logic       wdt_kick,
   output logic       rst_req,
   output logic       busy,
   output logic [1:0] cause,
   output logic       wdt_cnt_msb
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TMR_MAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_BTN  = 2'd1;
   localparam logic [1:0] CAUSE_WDT  = 2'd2;
   localparam logic [1:0] CAUSE_SW   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Button: 2-FF synchronizer, debounce, falling-edge event
   // ------------------------------------------------------------------
   logic            btn_s1;
   logic            btn_s2;
   logic            btn_db;
   logic            btn_db_d;
   logic [DB_W-1:0] db_cnt;
   logic            btn_evt;

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1   <= 1'b1;
         btn_s2   <= 1'b1;
         btn_db   <= 1'b1;
         btn_db_d <= 1'b1;
         db_cnt   <= '0;
      end else begin
         btn_s1   <= btn_n;
         btn_s2   <= btn_s1;
         btn_db_d <= btn_db;
         if (btn_s2 != btn_db) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               btn_db <= btn_s2;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   // Only a press (released -> pressed) is an event; release is silent.
   assign btn_evt = btn_db_d & ~btn_db;

   // ------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------
   state_t           state;
   state_t           state_d;
   logic [WDT_W-1:0] wdt_cnt;
   logic             wdt_evt;

   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_cnt <= '0;
      end else if (!wdt_en || wdt_kick || (state != ST_IDLE)) begin
         wdt_cnt <= '0;
      end else begin
         wdt_cnt <= wdt_cnt + 1'b1;
      end
   end

   // A kick on the terminal cycle suppresses the event; the counter wraps to 0 on its own.
   assign wdt_evt     = wdt_en && !wdt_kick && (wdt_cnt == {WDT_W{1'b1}});
   assign wdt_cnt_msb = wdt_cnt[WDT_W-1];

   // ------------------------------------------------------------------
   // Request FSM with one shared down-counter for pulse and holdoff
   // ------------------------------------------------------------------
   logic [TMR_W-1:0] tmr;
   logic [TMR_W-1:0] tmr_d;
   logic             any_evt;
   logic             rst_req_d;
   logic             busy_d;
   logic [1:0]       cause_d;

   assign any_evt = btn_evt | wdt_evt | sw_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         tmr     <= '0;
         rst_req <= 1'b0;
         busy    <= 1'b0;
         cause   <= CAUSE_NONE;
      end else begin
         state   <= state_d;
         tmr     <= tmr_d;
         rst_req <= rst_req_d;
         busy    <= busy_d;
         cause   <= cause_d;
      end
   end

   always_comb begin
      state_d = state;
      tmr_d   = tmr;
      case (state)
         ST_IDLE: begin
            if (any_evt) begin
               state_d = ST_ASSERT;
               tmr_d   = TMR_W'(PULSE_LEN - 1);
            end
         end
         ST_ASSERT: begin
            if (tmr == '0) begin
               state_d = ST_HOLDOFF;
               tmr_d   = TMR_W'(HOLDOFF - 1);
            end else begin
               tmr_d = tmr - 1'b1;
            end
         end
         ST_HOLDOFF: begin
            if (tmr == '0) begin
               state_d = ST_IDLE;
            end else begin
               tmr_d = tmr - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so no input reaches a port combinationally.
   always_comb begin
      rst_req_d = (state_d == ST_ASSERT);
      busy_d    = (state_d != ST_IDLE);
      cause_d   = cause;
      if ((state == ST_IDLE) && any_evt) begin
         if (btn_evt) begin
            cause_d = CAUSE_BTN;
         end else if (wdt_evt) begin
            cause_d = CAUSE_WDT;
         end else begin
            cause_d = CAUSE_SW;
         end
      end
   end

endmodule

// File: tb/tb_rst_req_gen.sv
// tb/tb_rst_req_gen.sv - directed self-checking bench for rst_req_gen
module tb_rst_req_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_n = 1'b1;
   logic       sw_req = 1'b0;
   logic       wdt_en = 1'b0;
   logic       wdt_kick = 1'b0;
   logic       rst_req;
   logic       busy;
   logic [1:0] cause;
   logic       wdt_cnt_msb;

   int pass_cnt = 0;
   int total_cnt = 0;

   rst_req_gen #(
      .DEBOUNCE_CYCLES(4),
      .WDT_W(6),
      .PULSE_LEN(3),
      .HOLDOFF(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_n(btn_n),
      .sw_req(sw_req),
      .wdt_en(wdt_en),
      .wdt_kick(wdt_kick),
      .rst_req(rst_req),
      .busy(busy),
      .cause(cause),
      .wdt_cnt_msb(wdt_cnt_msb)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      btn_n = 1'b1; sw_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if (rst_req !== 1'b0) $display("FAIL reset_rst_req actual=%b required=0", rst_req); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy actual=%b required=0", busy); else pass_cnt++;
      total_cnt++;
      if (cause !== 2'd0) $display("FAIL reset_cause actual=%0d required=0", cause); else pass_cnt++;
      total_cnt++;
      if (wdt_cnt_msb !== 1'b0) $display("FAIL reset_wdt_msb actual=%b required=0", wdt_cnt_msb); else pass_cnt++;
   endtask

   task automatic test_button();
      int glitch_hi = 0;
      int first = -1;
      int hi = 0;
      int bz = 0;
      int rises = 0;
      logic prev = 1'b0;
      do_reset();
      for (int g = 0; g < 3; g++) begin
         btn_n = 1'b0;
         repeat (2) begin step(); if (rst_req) glitch_hi++; end
         btn_n = 1'b1;
         repeat (4) begin step(); if (rst_req) glitch_hi++; end
      end
      total_cnt++;
      if (glitch_hi !== 0) $display("FAIL btn_glitch actual=%0d required=0", glitch_hi); else pass_cnt++;
      btn_n = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (rst_req && first < 0) first = i;
         if (rst_req) hi++;
         if (busy) bz++;
         if (rst_req && !prev) rises++;
         prev = rst_req;
         if (i == 10) btn_n = 1'b1;
      end
      total_cnt++;
      if (first !== 7) $display("FAIL btn_latency actual=%0d required=7", first); else pass_cnt++;
      total_cnt++;
      if (hi !== 3) $display("FAIL btn_pulse_len actual=%0d required=3", hi); else pass_cnt++;
      total_cnt++;
      if (bz !== 8) $display("FAIL btn_busy_len actual=%0d required=8", bz); else pass_cnt++;
      total_cnt++;
      if (rises !== 1) $display("FAIL btn_event_count actual=%0d required=1", rises); else pass_cnt++;
      total_cnt++;
      if (cause !== 2'd1) $display("FAIL btn_cause actual=%0d required=1", cause); else pass_cnt++;
   endtask

   task automatic test_watchdog();
      int first = -1;
      int hi = 0;
      logic msb31 = 1'b1;
      logic msb40 = 1'b0;
      do_reset();
      wdt_en = 1'b1;
      for (int i = 1; i <= 80; i++) begin
         step();
         if (i == 31) msb31 = wdt_cnt_msb;
         if (i == 40) msb40 = wdt_cnt_msb;
         if (rst_req && first < 0) first = i;
      end
      total_cnt++;
      if (msb31 !== 1'b0) $display("FAIL wdt_msb_31 actual=%b required=0", msb31); else pass_cnt++;
      total_cnt++;
      if (msb40 !== 1'b1) $display("FAIL wdt_msb_40 actual=%b required=1", msb40); else pass_cnt++;
      total_cnt++;
      if (first !== 64) $display("FAIL wdt_timeout actual=%0d required=64", first); else pass_cnt++;
      total_cnt++;
      if (cause !== 2'd2) $display("FAIL wdt_cause actual=%0d required=2", cause); else pass_cnt++;
      do_reset();
      wdt_en = 1'b1;
      for (int i = 1; i <= 1000; i++) begin
         wdt_kick = ((i % 60) == 0);
         step();
         if (rst_req) hi++;
      end
      wdt_kick = 1'b0;
      total_cnt++;
      if (hi !== 0) $display("FAIL wdt_kicked actual=%0d required=0", hi); else pass_cnt++;
   endtask

   task automatic test_priority();
      int hi = 0;
      do_reset();
      wdt_en = 1'b1;
      repeat (63) step();
      sw_req = 1'b1;
      step();
      sw_req = 1'b0;
      wdt_en = 1'b0;
      if (rst_req) hi++;
      for (int i = 1; i <= 25; i++) begin
         step();
         if (rst_req) hi++;
         sw_req = (i == 4);
      end
      sw_req = 1'b0;
      total_cnt++;
      if (hi !== 3) $display("FAIL prio_pulse_count actual=%0d required=3", hi); else pass_cnt++;
      total_cnt++;
      if (cause !== 2'd2) $display("FAIL prio_cause actual=%0d required=2", cause); else pass_cnt++;
   endtask

   task automatic test_rst_mid_pulse();
      do_reset();
      sw_req = 1'b1;
      step();
      sw_req = 1'b0;
      total_cnt++;
      if (rst_req !== 1'b1) $display("FAIL midrst_first actual=%b required=1", rst_req); else pass_cnt++;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      total_cnt++;
      if (rst_req !== 1'b0) $display("FAIL midrst_rst_req actual=%b required=0", rst_req); else pass_cnt++;
      total_cnt++;
      if (cause !== 2'd0) $display("FAIL midrst_cause actual=%0d required=0", cause); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL midrst_busy actual=%b required=0", busy); else pass_cnt++;
      sw_req = 1'b1;
      step();
      sw_req = 1'b0;
      total_cnt++;
      if (rst_req !== 1'b1) $display("FAIL midrst_refire actual=%b required=1", rst_req); else pass_cnt++;
      total_cnt++;
      if (cause !== 2'd3) $display("FAIL midrst_sw_cause actual=%0d required=3", cause); else pass_cnt++;
   endtask

   task automatic test_btn_held();
      int hi = 0;
      int first = -1;
      do_reset();
      sw_req = 1'b1;
      step();
      sw_req = 1'b0;
      btn_n = 1'b0;
      if (rst_req) hi++;
      repeat (30) begin step(); if (rst_req) hi++; end
      total_cnt++;
      if (hi !== 3) $display("FAIL held_no_extra actual=%0d required=3", hi); else pass_cnt++;
      total_cnt++;
      if (cause !== 2'd3) $display("FAIL held_cause actual=%0d required=3", cause); else pass_cnt++;
      btn_n = 1'b1;
      repeat (12) step();
      btn_n = 1'b0;
      hi = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (rst_req && first < 0) first = i;
         if (rst_req) hi++;
      end
      btn_n = 1'b1;
      total_cnt++;
      if (first !== 7) $display("FAIL repress_latency actual=%0d required=7", first); else pass_cnt++;
      total_cnt++;
      if (hi !== 3) $display("FAIL repress_pulse actual=%0d required=3", hi); else pass_cnt++;
      total_cnt++;
      if (cause !== 2'd1) $display("FAIL repress_cause actual=%0d required=1", cause); else pass_cnt++;
   endtask

   task automatic test_kick_terminal();
      int first = -1;
      do_reset();
      wdt_en = 1'b1;
      repeat (63) step();
      total_cnt++;
      if (wdt_cnt_msb !== 1'b1) $display("FAIL term_msb actual=%b required=1", wdt_cnt_msb); else pass_cnt++;
      wdt_kick = 1'b1;
      step();
      wdt_kick = 1'b0;
      total_cnt++;
      if (wdt_cnt_msb !== 1'b0) $display("FAIL term_cleared actual=%b required=0", wdt_cnt_msb); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL term_no_event actual=%b required=0", busy); else pass_cnt++;
      for (int i = 1; i <= 80; i++) begin
         step();
         if (rst_req && first < 0) first = i;
      end
      total_cnt++;
      if (first !== 64) $display("FAIL term_restart actual=%0d required=64", first); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_button();
      test_watchdog();
      test_priority();
      test_rst_mid_pulse();
      test_btn_held();
      test_kick_terminal();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
